// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-to-stream adapter and its
// 2-entry output buffer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH      = 2;

  // Output buffer occupancy; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head in r_buf0, tail in r_buf1. A push and a pop
// in the same cycle keep occupancy unchanged and preserve order.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head
);

  occ_e                  r_state;
  occ_e                  w_state_next;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  w_do_pop;

  assign w_do_pop = i_pop & (r_state != EMPTY);

  // NOTE: clocked blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default comes first so every path assigns w_state_next (no latch).
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (i_push) w_state_next = ONE;
        ONE: begin
          if (i_push && !w_do_pop) begin
            w_state_next = TWO;
          end else if (!i_push && w_do_pop) begin
            w_state_next = EMPTY;
          end
        end
        // Push without pop in TWO is excluded by the read-issue throttle.
        TWO: if (w_do_pop && !i_push) w_state_next = ONE;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // NOTE: both words are reset so m_data reads 0 while reset is held; a deep
  // data memory would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (!i_flush) begin
      unique case (r_state)
        EMPTY: if (i_push) r_buf0 <= i_data;
        ONE: begin
          if (i_push && w_do_pop) begin
            r_buf0 <= i_data;
          end else if (i_push) begin
            r_buf1 <= i_data;
          end
        end
        TWO: begin
          if (w_do_pop) begin
            r_buf0 <= r_buf1;
            if (i_push) r_buf1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ   = r_state;
  assign o_valid = (r_state != EMPTY);
  assign o_head  = r_buf0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream via fifo_rd_skid.
// Optional pop counter output beat_cnt when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  localparam logic [2:0] BUF_DEPTH_W = 3'(BUF_DEPTH);

  if (CNT_WIDTH < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("fifo_rd_stream: DATA_WIDTH and CNT_WIDTH must be at least 1");
  end

  logic       r_inflight;
  logic [1:0] w_occ;
  logic       w_pop;
  logic [2:0] w_occ_after;

  assign w_pop       = m_valid & m_ready;
  assign w_occ_after = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Reset gates the request combinationally so no read is issued while held.
  assign fifo_rd_en = rst & ~fifo_empty & ~flush & (w_occ_after < BUF_DEPTH_W);

  // Flush already forces fifo_rd_en low, which clears the flag next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (flush),
    .i_push  (r_inflight & ~flush),
    .i_data  (fifo_data_out),
    .i_pop   (w_pop & ~flush),
    .o_occ   (w_occ),
    .o_valid (m_valid),
    .o_head  (m_data)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] r_beat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (flush) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO model, queue-based stream
// reference, directed table and sequences, then random traffic.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CW-1:0] beat_cnt;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt      (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            e;   // edge count after which the read was issued
  } ent_t;

  typedef struct {
    logic          rdy;
    logic          fl;
    logic          e_rd;
    logic          e_v;
    logic [DW-1:0] e_d;
  } vec_t;

  logic [DW-1:0] fifo_q[$];
  ent_t          exp_q[$];
  logic [DW-1:0] got_q[$];
  int            edge_idx = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_reads = 0;
  int            n_pops = 0;
  int            cnt_model = 0;
  logic          last_rd, last_valid, last_pop;
  logic [DW-1:0] last_data, last_pop_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the reference, advance the models.
  task automatic step(input logic rdy, input logic fl);
    logic          exp_v, exp_rd, rd, pop, got;
    logic [DW-1:0] w;
    int            held;
    m_ready    = rdy;
    flush      = fl;
    fifo_empty = (fifo_q.size() == 0);
    got        = 1'b0;
    w          = '0;
    #1;
    held  = exp_q.size();
    exp_v = 1'b0;
    if (rst && held > 0) exp_v = (exp_q[0].e < edge_idx);
    exp_rd = rst && !fifo_empty && !fl && ((held - ((exp_v && rdy) ? 1 : 0)) < 2);
    check("m_valid", m_valid, exp_v);
    check("fifo_rd_en", fifo_rd_en, exp_rd);
    if (exp_v) check("m_data", m_data, exp_q[0].d);
    if (!rst) check("m_data_in_reset", m_data, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("beat_cnt", beat_cnt, cnt_model % (1 << CW));
`endif
    last_rd       = fifo_rd_en;
    last_valid    = m_valid;
    last_data     = m_data;
    last_pop      = m_valid && rdy && !fl;
    last_pop_data = m_data;
    rd            = fifo_rd_en;
    pop           = exp_v && rdy && !fl;
    if (!rst || fl) begin
      exp_q.delete();
      cnt_model = 0;
    end else if (pop) begin
      void'(exp_q.pop_front());
      cnt_model++;
    end
    if (rd) begin
      check("no_over_read", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) begin
        w   = fifo_q.pop_front();
        got = 1'b1;
        if (rst && !fl) exp_q.push_back('{d: w, e: edge_idx + 1});
      end
      n_reads++;
    end
    if (last_pop) n_pops++;
    @(posedge clk);
    edge_idx++;
    #1;
    fifo_data_out = got ? w : DW'($urandom);
    check("no_overflow", exp_q.size() <= 2, 1);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vt[6];
    int            r0, p0;
    logic          found;
    logic [DW-1:0] first;

    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset held with a non-empty FIFO: no reads, outputs cleared.
    @(negedge clk);
    fifo_q.push_back(8'h5A);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("drain_after_reset_pops", n_pops, 1);

    // Three-word burst, ready high: cycle-by-cycle table.
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    for (int i = 0; i < 6; i++) begin
      step(vt[i].rdy, vt[i].fl);
      check($sformatf("vec%0d_rd_en", i), last_rd, vt[i].e_rd);
      check($sformatf("vec%0d_valid", i), last_valid, vt[i].e_v);
      if (vt[i].e_v) check($sformatf("vec%0d_data", i), last_data, vt[i].e_d);
    end

    // Backpressure: only two reads, head held stable, then no-gap drain.
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA1 + 8'(i));
    r0 = n_reads;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("bp_reads", n_reads - r0, 2);
    check("bp_valid_held", last_valid, 1);
    check("bp_data_held", last_data, 8'hA1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("bp_nogap%0d", i), last_pop, 1);
      check($sformatf("bp_order%0d", i), last_pop_data, 8'hA1 + 8'(i));
    end

    // Ready toggling 1010 over eight words.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    got_q.delete();
    for (int i = 0; i < 24; i++) begin
      step(i % 2 == 0, 1'b0);
      if (last_pop) got_q.push_back(last_pop_data);
    end
    check("toggle_beats", got_q.size(), 8);
    for (int k = 0; k < got_q.size(); k++) check($sformatf("toggle_beat%0d", k), got_q[k], k + 1);

    // Flush with one buffered word and one in flight.
    fifo_q.push_back(8'hB1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    fifo_q.push_back(8'hB2);
    fifo_q.push_back(8'hB3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("flush_valid_cleared", m_valid, 0);
    found = 1'b0;
    first = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      if (last_pop && !found) begin
        found = 1'b1;
        first = last_pop_data;
      end
    end
    check("flush_beat_seen", found, 1);
    check("flush_first_beat", first, 8'hB3);

    // Asynchronous reset mid-stream (one buffered, one in flight).
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hC1 + 8'(i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_valid", m_valid, 0);
    check("rst_async_rd_en", fifo_rd_en, 0);
    check("rst_async_data", m_data, 0);
    exp_q.delete();
    cnt_model = 0;
    @(negedge clk);
    step(1'b1, 1'b0);
    rst = 1'b1;
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (last_pop) got_q.push_back(last_pop_data);
    end
    check("rst_resume_beats", got_q.size(), 2);
    if (got_q.size() > 0) check("rst_resume_first", got_q[0], 8'hC3);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wrap at CNT_WIDTH=4 and clear on flush.
    step(1'b0, 1'b1);
    check("cnt_cleared_pre", beat_cnt, 0);
    p0 = n_pops;
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h40 + i));
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
    check("cnt_pops17", n_pops - p0, 17);
    check("cnt_wrap", beat_cnt, 1);
    step(1'b0, 1'b1);
    check("cnt_flush", beat_cnt, 0);
`else
    p0 = n_pops;
`endif

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16) fifo_q.push_back(DW'($urandom));
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4);
    end
    fifo_q.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check("random_made_progress", n_pops > p0, 1);
    check("random_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
